// File: rtl/ddr_wr_burst.sv
// ddr_wr_burst
//   Buffers framed 128-bit pixel words in an internal FIFO and drains them to
//   DDR3 as Avalon-MM burst writes. Each frame goes into a frame bank; the bank
//   that holds the most recently completed frame is reported on rd_bank.
//
//   Build option: define WR_PINGPONG_EN to alternate frames between two banks
//   (bank 1 sits BANK_OFFSET words above bank 0). Without it, every frame is
//   written from BANK0_BASE and rd_bank is constant 0.
//
// Ports
//   clk              DDR user clock
//   rst_n            asynchronous active-low reset
//   din              pixel word
//   din_sop          first word of frame (qualified by din_vld)
//   din_eop          last word of frame (qualified by din_vld)
//   din_vld          word valid, no backpressure
//   avm_address      burst start word address, held for the whole burst
//   avm_burstcount   beats in current burst, held for the whole burst
//   avm_write        write request
//   avm_writedata    write data (FIFO head)
//   avm_waitrequest  slave stall
//   rd_bank          bank holding the last completed frame
//   frame_done       one-cycle pulse when a frame is fully written
//   ovf              sticky FIFO overflow flag
module ddr_wr_burst #(
   parameter int DW          = 128,
   parameter int AW          = 28,
   parameter int BURST_LEN   = 64,
   parameter int FIFO_DEPTH  = 512,
   parameter int BANK0_BASE  = 0,
   parameter int BANK_OFFSET = 131072
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] din,
   input  logic          din_sop,
   input  logic          din_eop,
   input  logic          din_vld,
   output logic [AW-1:0] avm_address,
   output logic [7:0]    avm_burstcount,
   output logic          avm_write,
   output logic [DW-1:0] avm_writedata,
   input  logic          avm_waitrequest,
   output logic          rd_bank,
   output logic          frame_done,
   output logic          ovf
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [AW-1:0] BASE0 = AW'(BANK0_BASE);

   typedef enum logic [1:0] {IDLE, WR, DONE} state_t;

   state_t state_reg, state_next;

   // FIFO storage and pointers
   logic [DW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] cnt_reg;
   logic [DW-1:0] head_reg;

   logic sop_acc, gate_in, fifo_full, wr_en, pop;
   logic in_frame_reg, eop_pending_reg, ovf_reg;

   logic [AW-1:0] addr_reg, offset_reg, bank_base;
   logic [7:0]    bcnt_reg, beat_reg, load_len;
   logic          load_burst, last_beat;

   // A sop is only honoured once the previous frame has fully drained;
   // otherwise the whole new frame is ignored until a later sop.
   assign sop_acc   = din_vld & din_sop & ~eop_pending_reg;
   assign gate_in   = din_vld & (in_frame_reg | sop_acc);
   assign fifo_full = (cnt_reg == CW'(FIFO_DEPTH));
   assign wr_en     = gate_in & ~fifo_full;
   assign rd_ptr_next = rd_ptr_reg + PW'(pop);

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_reg] <= din;
   end

   // Show-ahead head register: it reads the location that will be at the head
   // next cycle. When that location is being written right now (empty FIFO,
   // or last word popped while a new one arrives), take din directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         cnt_reg    <= '0;
         head_reg   <= '0;
      end else begin
         if (wr_en)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         rd_ptr_reg <= rd_ptr_next;
         cnt_reg    <= cnt_reg + CW'(wr_en) - CW'(pop);
         if (wr_en && (wr_ptr_reg == rd_ptr_next))
            head_reg <= din;
         else
            head_reg <= mem[rd_ptr_next];
      end
   end

   always_comb begin
      state_next = state_reg;
      avm_write  = 1'b0;
      frame_done = 1'b0;
      pop        = 1'b0;
      load_burst = 1'b0;
      load_len   = '0;
      last_beat  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cnt_reg >= CW'(BURST_LEN)) begin
               load_burst = 1'b1;
               load_len   = 8'(BURST_LEN);
               state_next = WR;
            end else if (eop_pending_reg && (cnt_reg != '0)) begin
               // frame tail: shorter than a full burst
               load_burst = 1'b1;
               load_len   = 8'(cnt_reg);
               state_next = WR;
            end else if (eop_pending_reg) begin
               state_next = DONE;
            end
         end
         WR: begin
            avm_write = 1'b1;
            pop       = ~avm_waitrequest;
            last_beat = pop && (beat_reg == bcnt_reg - 8'd1);
            if (last_beat)
               state_next = IDLE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         addr_reg        <= BASE0;
         bcnt_reg        <= '0;
         beat_reg        <= '0;
         offset_reg      <= '0;
         in_frame_reg    <= 1'b0;
         eop_pending_reg <= 1'b0;
         ovf_reg         <= 1'b0;
      end else begin
         state_reg <= state_next;

         if (load_burst) begin
            addr_reg <= bank_base + offset_reg;
            bcnt_reg <= load_len;
         end

         if (pop)
            beat_reg <= last_beat ? 8'd0 : beat_reg + 8'd1;

         if (sop_acc)
            offset_reg <= '0;
         else if (last_beat)
            offset_reg <= offset_reg + AW'(bcnt_reg);

         // eop after sop on the same word closes the frame: one-word frame
         if (sop_acc)
            in_frame_reg <= 1'b1;
         if (gate_in && din_eop)
            in_frame_reg <= 1'b0;

         if (gate_in && din_eop)
            eop_pending_reg <= 1'b1;
         else if (state_reg == DONE)
            eop_pending_reg <= 1'b0;

         if (gate_in && fifo_full)
            ovf_reg <= 1'b1;
      end
   end

`ifdef WR_PINGPONG_EN
   localparam logic [AW-1:0] BASE1 = AW'(BANK0_BASE + BANK_OFFSET);
   logic wr_bank_reg, rd_bank_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank_reg <= 1'b0;
         rd_bank_reg <= 1'b0;
      end else if (state_reg == DONE) begin
         rd_bank_reg <= wr_bank_reg;
         wr_bank_reg <= ~wr_bank_reg;
      end
   end

   assign bank_base = wr_bank_reg ? BASE1 : BASE0;
   assign rd_bank   = rd_bank_reg;
`else
   assign bank_base = BASE0;
   assign rd_bank   = 1'b0;
`endif

   assign avm_address    = addr_reg;
   assign avm_burstcount = bcnt_reg;
   assign avm_writedata  = head_reg;
   assign ovf            = ovf_reg;

endmodule

// File: tb/tb_ddr_wr_burst.sv
// tb_ddr_wr_burst
//   Directed bench for ddr_wr_burst with BURST_LEN=4 and FIFO_DEPTH=8.
//   A negedge monitor logs every accepted beat and frame_done pulse; the main
//   sequence sends frames and compares the logged beats against hand-computed
//   addresses, burst counts and data. Works with or without WR_PINGPONG_EN.
module tb_ddr_wr_burst;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [127:0]  din;
   logic          din_sop, din_eop, din_vld;
   logic [27:0]   avm_address;
   logic [7:0]    avm_burstcount;
   logic          avm_write;
   logic [127:0]  avm_writedata;
   logic          avm_waitrequest;
   logic          rd_bank, frame_done, ovf;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [27:0]  a;
      logic [7:0]   bc;
      logic [127:0] d;
   } beat_t;

   beat_t q[$];
   int    beat_total  = 0;
   int    fd_cnt      = 0;
   int    beats_at_fd = 0;
   logic  cur_bank    = 1'b0;

   always #5 clk = ~clk;

   ddr_wr_burst #(
      .DW(128), .AW(28), .BURST_LEN(4), .FIFO_DEPTH(8),
      .BANK0_BASE(0), .BANK_OFFSET(131072)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .din(din),
      .din_sop(din_sop),
      .din_eop(din_eop),
      .din_vld(din_vld),
      .avm_address(avm_address),
      .avm_burstcount(avm_burstcount),
      .avm_write(avm_write),
      .avm_writedata(avm_writedata),
      .avm_waitrequest(avm_waitrequest),
      .rd_bank(rd_bank),
      .frame_done(frame_done),
      .ovf(ovf)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] word(input int tag, input int i);
      return {32'(tag), 64'hDEADBEEF_0BADF00D, 32'(i)};
   endfunction

   function automatic logic [27:0] base_of(input logic b);
`ifdef WR_PINGPONG_EN
      return b ? 28'd131072 : 28'd0;
`else
      return (b === 1'bx) ? 28'd1 : 28'd0;
`endif
   endfunction

   // Beats accepted at the next posedge are visible on this negedge.
   always @(negedge clk) begin
      if (avm_write && !avm_waitrequest) begin
         q.push_back('{a: avm_address, bc: avm_burstcount, d: avm_writedata});
         beat_total++;
         $display("beat addr=%0d bc=%0d data=%h", avm_address, avm_burstcount, avm_writedata);
      end
      if (frame_done) begin
         fd_cnt++;
         beats_at_fd = beat_total;
         $display("frame_done #%0d after %0d beats, rd_bank(before)=%0b", fd_cnt, beat_total, rd_bank);
      end
   end

   task automatic drive(input logic [127:0] d, input logic s, input logic e, input logic v);
      @(posedge clk);
      #1;
      din = d; din_sop = s; din_eop = e; din_vld = v;
   endtask

   task automatic send_frame(input int tag, input int n);
      for (int i = 0; i < n; i++)
         drive(word(tag, i), i == 0, i == n - 1, 1'b1);
      drive('0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_burst(input logic [27:0] a, input int bc, input int tag, input int first);
      beat_t b;
      for (int i = 0; i < bc; i++) begin
         chk("beat_present", 128'(q.size() > 0), 128'(1));
         if (q.size() == 0)
            break;
         b = q.pop_front();
         chk("burst_addr", 128'(b.a), 128'(a));
         chk("burst_count", 128'(b.bc), 128'(bc));
         chk("burst_data", b.d, word(tag, first + i));
      end
   endtask

   task automatic finish_frame(input int target, input int cum);
      int k = 0;
      while (fd_cnt < target && k < 300) begin
         @(posedge clk);
         k++;
      end
      chk("frame_done_cnt", 128'(fd_cnt), 128'(target));
      chk("beats_at_done", 128'(beats_at_fd), 128'(cum));
      repeat (2) @(posedge clk);
      #1;
      chk("frame_done_low", 128'(frame_done), 128'(0));
`ifdef WR_PINGPONG_EN
      chk("rd_bank", 128'(rd_bank), 128'(cur_bank));
      cur_bank = ~cur_bank;
`else
      chk("rd_bank", 128'(rd_bank), 128'(0));
`endif
   endtask

   initial begin
      logic fb;
      int   k;
      rst_n = 1'b0;
      din = '0; din_sop = 1'b0; din_eop = 1'b0; din_vld = 1'b0;
      avm_waitrequest = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_write", 128'(avm_write), 128'(0));
      chk("rst_addr", 128'(avm_address), 128'(0));
      chk("rst_bc", 128'(avm_burstcount), 128'(0));
      chk("rst_wdata", avm_writedata, 128'(0));
      chk("rst_rd_bank", 128'(rd_bank), 128'(0));
      chk("rst_frame_done", 128'(frame_done), 128'(0));
      chk("rst_ovf", 128'(ovf), 128'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;

      // two 8-word frames, no stalls
      fb = cur_bank;
      send_frame(1, 8);
      finish_frame(1, 8);
      check_burst(base_of(fb), 4, 1, 0);
      check_burst(base_of(fb) + 28'd4, 4, 1, 4);
      chk("q_empty_f1", 128'(q.size()), 128'(0));

      fb = cur_bank;
      send_frame(2, 8);
      finish_frame(2, 16);
      check_burst(base_of(fb), 4, 2, 0);
      check_burst(base_of(fb) + 28'd4, 4, 2, 4);
      chk("q_empty_f2", 128'(q.size()), 128'(0));

      // 6-word frame: bursts of 4 then 2
      fb = cur_bank;
      send_frame(3, 6);
      finish_frame(3, 22);
      check_burst(base_of(fb), 4, 3, 0);
      check_burst(base_of(fb) + 28'd4, 2, 3, 4);
      chk("q_empty_f3", 128'(q.size()), 128'(0));

      // stall for 3 cycles after the second beat of the first burst
      fb = cur_bank;
      avm_waitrequest = 1'b1;
      send_frame(4, 8);
      avm_waitrequest = 1'b0;
      k = 0;
      while (q.size() < 2 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("stall_pre_beats", 128'(q.size()), 128'(2));
      avm_waitrequest = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_write", 128'(avm_write), 128'(1));
         chk("stall_addr", 128'(avm_address), 128'(base_of(fb)));
         chk("stall_bc", 128'(avm_burstcount), 128'(4));
         chk("stall_data", avm_writedata, word(4, 2));
      end
      @(posedge clk);
      #1 avm_waitrequest = 1'b0;
      finish_frame(4, 30);
      check_burst(base_of(fb), 4, 4, 0);
      check_burst(base_of(fb) + 28'd4, 4, 4, 4);
      chk("q_empty_f4", 128'(q.size()), 128'(0));

      // overflow: 12 words into an 8-deep FIFO with the slave stalled
      fb = cur_bank;
      avm_waitrequest = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(word(5, i), i == 0, i == 11, 1'b1);
         if (i == 8) chk("ovf_before_9th", 128'(ovf), 128'(0));
         if (i == 9) chk("ovf_after_9th", 128'(ovf), 128'(1));
      end
      drive('0, 1'b0, 1'b0, 1'b0);
      chk("ovf_no_beats", 128'(q.size()), 128'(0));
      avm_waitrequest = 1'b0;
      finish_frame(5, 38);
      check_burst(base_of(fb), 4, 5, 0);
      check_burst(base_of(fb) + 28'd4, 4, 5, 4);
      chk("q_empty_f5", 128'(q.size()), 128'(0));

      // stray words before sop, then a sop while the previous frame drains
      for (int i = 0; i < 3; i++)
         drive(word(6, i), 1'b0, 1'b0, 1'b1);
      drive('0, 1'b0, 1'b0, 1'b0);
      fb = cur_bank;
      avm_waitrequest = 1'b1;
      send_frame(7, 4);
      send_frame(8, 3);
      avm_waitrequest = 1'b0;
      finish_frame(6, 42);
      check_burst(base_of(fb), 4, 7, 0);
      chk("q_empty_f7", 128'(q.size()), 128'(0));

      fb = cur_bank;
      send_frame(9, 2);
      finish_frame(7, 44);
      check_burst(base_of(fb), 2, 9, 0);
      chk("q_empty_f9", 128'(q.size()), 128'(0));

      // one-word frame: sop and eop on the same word
      fb = cur_bank;
      send_frame(10, 1);
      finish_frame(8, 45);
      check_burst(base_of(fb), 1, 10, 0);
      chk("q_empty_f10", 128'(q.size()), 128'(0));
      chk("ovf_sticky", 128'(ovf), 128'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ddr_wr_burst.md
Name: ddr_wr_burst

Overview:
- Downstream of the camera capture stage, in the DDR3 user-clock domain. The capture stage's 128-bit packets reach this block through the existing dual-clock FIFO.
- Accepts 128-bit pixel words framed by sop/eop and buffers them in an internal synchronous FIFO.
- Issues Avalon-MM burst writes to DDR3 into one of two frame banks (ping-pong). Reports which bank holds the latest complete frame for the HDMI read side.

Parameters:
- DW, 128, data width of pixel word and DDR user bus.
- AW, 28, DDR word-address width.
- BURST_LEN, 64, maximum beats per write burst (power of 2, 2..128).
- FIFO_DEPTH, 512, internal FIFO depth in words (power of 2, at least 2*BURST_LEN).
- BANK0_BASE, 0, word address of bank 0.
- BANK_OFFSET, 131072, word-address distance from bank 0 to bank 1 (must be at least 1280*720/8 = 115200).

Ports:
- clk  in  1  DDR user clock
- rst_n  in  1  asynchronous active-low reset
- din  in  DW  pixel word
- din_sop  in  1  first word of frame (qualified by din_vld)
- din_eop  in  1  last word of frame (qualified by din_vld)
- din_vld  in  1  word valid; no backpressure
- avm_address  out  AW  burst start word address
- avm_burstcount  out  8  beats in current burst
- avm_write  out  1  write request
- avm_writedata  out  DW  write data
- avm_waitrequest  in  1  slave stall
- rd_bank  out  1  bank holding last completed frame
- frame_done  out  1  one-cycle pulse when a frame is fully written
- ovf  out  1  sticky FIFO overflow flag

Behaviour:
- Reset values: avm_write=0, avm_address=BANK0_BASE, avm_burstcount=0, avm_writedata=0, rd_bank=0, frame_done=0, ovf=0. Internal state: wr_bank=0, offset=0, state IDLE, FIFO empty, in_frame=0, eop_pending=0.
- Input gating (drives in_frame):
  - Words with din_vld=1 are written to the FIFO only while in_frame=1, or on the sop word itself.
  - din_sop&din_vld with eop_pending=0: in_frame=1; offset is cleared when the sop word enters the FIFO.
  - din_sop&din_vld with eop_pending=1 (previous frame still draining): whole new frame dropped; in_frame stays 0 until a later sop.
  - din_eop&din_vld: word written, in_frame=0, eop_pending=1.
  - Simultaneous sop&eop on one word: treated as a one-word frame.
- Overflow: din_vld while FIFO full and gated in → word dropped, ovf=1 until reset. Frame still completes with fewer words.
- FIFO: show-ahead read. fifo_cnt is updated on the same cycle for simultaneous read and write.
- FSM:
  - IDLE:
    - If fifo_cnt >= BURST_LEN: burstcount=BURST_LEN → WR.
    - Else if eop_pending and fifo_cnt>0: burstcount=fifo_cnt → WR.
    - Else if eop_pending and fifo_cnt==0 → DONE.
  - WR:
    - avm_write=1. avm_address=base(wr_bank)+offset and avm_burstcount are held constant for the whole burst.
    - avm_writedata = FIFO head. A beat is accepted when avm_write & !avm_waitrequest; FIFO pops on accept.
    - After the last beat is accepted: avm_write=0, offset += burstcount → IDLE.
  - DONE (1 cycle): frame_done=1, rd_bank=wr_bank, wr_bank toggles, eop_pending=0 → IDLE.
- The first beat of a burst is presented one cycle after IDLE decides. No other bubbles between beats except waitrequest stalls.
- Address arithmetic: offset is AW bits and wraps modulo 2^AW. No bank-overrun protection; frames longer than BANK_OFFSET words overwrite the next bank.
- Reset mid-burst: avm_write drops immediately (async); FIFO contents and the partial frame are discarded.

Optional Feature:
- Macro WR_PINGPONG_EN.
- Defined: two banks as above; base(bank)=BANK0_BASE+bank*BANK_OFFSET.
- Undefined: single bank. All writes use BANK0_BASE, wr_bank and rd_bank are constant 0, frame_done is still pulsed.

Test Plan:
- BURST_LEN=4, ping-pong on; one frame of 8 words with sop on word 0 and eop on word 7; waitrequest=0 → two bursts at addresses 0 and 4, burstcount=4, data in order; frame_done pulse; rd_bank=0. Second identical frame → bursts at 131072 and 131076; rd_bank=1.
- Frame of 6 words, BURST_LEN=4 → bursts of 4 then 2 at offsets 0 and 4; frame_done after the second burst completes.
- Waitrequest held high 3 cycles mid-burst → address, burstcount and writedata stable during the stall; no beat lost or duplicated; total 8 beats.
- FIFO_DEPTH=8, waitrequest=1 constantly, 12 words input → ovf=1 after the 9th word; releasing waitrequest writes exactly 8 words.
- Words with din_vld before any sop, and sop arriving while eop_pending=1 → those words never appear on avm_writedata; next frame starts at offset 0.
- WR_PINGPONG_EN undefined, two frames → both written from address 0; rd_bank stays 0; two frame_done pulses.
